// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: opcode patterns, ALU control codes, the zero-register
// index and the control bundle carried through ID/EX.
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       uncond;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    function automatic logic is_rtype(input logic [10:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
    endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry register file: two combinational read ports with write-back bypass,
// one write port, X31 hardwired to zero.
module register_file
    import legv8_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] rd_addr1_i,
    input  logic [ADDR_BITS-1:0] rd_addr2_i,
    output logic [DATA_BITS-1:0] rd_data1_o,
    output logic [DATA_BITS-1:0] rd_data2_o,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [DATA_BITS-1:0] wr_data_i
);

    localparam int NREGS = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem_q [NREGS];

    // Register storage; writes to XZR are dropped so it never holds data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= {DATA_BITS{1'b0}};
            end
        end else if (wr_en_i && (wr_addr_i != XZR)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port 1 with same-cycle write-back bypass.
    always_comb begin
        rd_data1_o = {DATA_BITS{1'b0}};
        if (rd_addr1_i == XZR) begin
            rd_data1_o = {DATA_BITS{1'b0}};
        end else if (wr_en_i && (wr_addr_i == rd_addr1_i)) begin
            rd_data1_o = wr_data_i;
        end else begin
            rd_data1_o = mem_q[rd_addr1_i];
        end
    end

    // Read port 2 with same-cycle write-back bypass.
    always_comb begin
        rd_data2_o = {DATA_BITS{1'b0}};
        if (rd_addr2_i == XZR) begin
            rd_data2_o = {DATA_BITS{1'b0}};
        end else if (wr_en_i && (wr_addr_i == rd_addr2_i)) begin
            rd_data2_o = wr_data_i;
        end else begin
            rd_data2_o = mem_q[rd_addr2_i];
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// LEGv8 decode stage with ID/EX pipeline register: decode, register read,
// immediate extension, load-use stall and wrong-path squash after taken branches.
module id_ex_stage
    import legv8_pkg::*;
#(
    parameter int DATA_BITS     = 64,
    parameter int PC_BITS       = 10,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instruction_D,
    input  logic [PC_BITS-1:0]       current_pc_D,
    input  logic                     PCSrc,
    input  logic                     wb_en,
    input  logic [REG_ADDR_BITS-1:0] wb_addr,
    input  logic [DATA_BITS-1:0]     wb_data,
    output logic                     PCWrite,
    output logic                     IF_ID_Write,
    output logic                     reg_write_E,
    output logic                     mem_read_E,
    output logic                     mem_write_E,
    output logic                     mem_to_reg_E,
    output logic                     alu_src_E,
    output logic                     branch_E,
    output logic                     uncond_E,
    output logic [3:0]               alu_ctrl_E,
    output logic [DATA_BITS-1:0]     read_data1_E,
    output logic [DATA_BITS-1:0]     read_data2_E,
    output logic [DATA_BITS-1:0]     imm_E,
    output logic [REG_ADDR_BITS-1:0] rn_E,
    output logic [REG_ADDR_BITS-1:0] rm_E,
    output logic [REG_ADDR_BITS-1:0] rd_E,
    output logic [PC_BITS-1:0]       pc_E
);

    logic [10:0]              op_s;
    ctrl_t                    dec_ctrl_s;
    ctrl_t                    ctrl_d, ctrl_q;
    logic [DATA_BITS-1:0]     imm_s;
    logic                     use_rn_s, use_rm_s, stall_s;
    logic                     squash_d, squash_q;
    logic [REG_ADDR_BITS-1:0] rn_s, rm_s;
    logic [DATA_BITS-1:0]     rdata1_s, rdata2_s;
    logic [DATA_BITS-1:0]     rdata1_q, rdata2_q, imm_q;
    logic [REG_ADDR_BITS-1:0] rn_q, rm_q, rd_q;
    logic [PC_BITS-1:0]       pc_q;

    assign op_s = instruction_D[31:21];
    assign rn_s = instruction_D[9:5];

    // Decode: controls, which sources are really read, port-2 index and immediate.
    always_comb begin
        dec_ctrl_s = ctrl_t'(11'b0);
        imm_s      = {DATA_BITS{1'b0}};
        use_rn_s   = 1'b0;
        use_rm_s   = 1'b0;
        rm_s       = instruction_D[20:16];
        if (is_rtype(op_s)) begin
            dec_ctrl_s.reg_write = 1'b1;
            use_rn_s = 1'b1;
            use_rm_s = 1'b1;
            case (op_s)
                OP_SUB:  dec_ctrl_s.alu_ctrl = ALU_SUB;
                OP_AND:  dec_ctrl_s.alu_ctrl = ALU_AND;
                OP_ORR:  dec_ctrl_s.alu_ctrl = ALU_ORR;
                default: dec_ctrl_s.alu_ctrl = ALU_ADD;
            endcase
        end else if (op_s == OP_LDUR) begin
            dec_ctrl_s.alu_src    = 1'b1;
            dec_ctrl_s.mem_read   = 1'b1;
            dec_ctrl_s.mem_to_reg = 1'b1;
            dec_ctrl_s.reg_write  = 1'b1;
            dec_ctrl_s.alu_ctrl   = ALU_ADD;
            use_rn_s = 1'b1;
            imm_s    = {{(DATA_BITS-9){instruction_D[20]}}, instruction_D[20:12]};
        end else if (op_s == OP_STUR) begin
            dec_ctrl_s.alu_src   = 1'b1;
            dec_ctrl_s.mem_write = 1'b1;
            dec_ctrl_s.alu_ctrl  = ALU_ADD;
            use_rn_s = 1'b1;
            use_rm_s = 1'b1;
            rm_s     = instruction_D[4:0];
            imm_s    = {{(DATA_BITS-9){instruction_D[20]}}, instruction_D[20:12]};
        end else if (instruction_D[31:24] == OP_CBZ) begin
            dec_ctrl_s.branch   = 1'b1;
            dec_ctrl_s.alu_ctrl = ALU_PASSB;
            use_rm_s = 1'b1;
            rm_s     = instruction_D[4:0];
            imm_s    = {{(DATA_BITS-21){instruction_D[23]}}, instruction_D[23:5], 2'b00};
        end else if (instruction_D[31:26] == OP_B) begin
            dec_ctrl_s.uncond = 1'b1;
            imm_s = {{(DATA_BITS-28){instruction_D[25]}}, instruction_D[25:0], 2'b00};
        end else begin
            dec_ctrl_s = ctrl_t'(11'b0);
        end
    end

    register_file #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (REG_ADDR_BITS)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (reset),
        .rd_addr1_i (rn_s),
        .rd_addr2_i (rm_s),
        .rd_data1_o (rdata1_s),
        .rd_data2_o (rdata2_s),
        .wr_en_i    (wb_en),
        .wr_addr_i  (wb_addr),
        .wr_data_i  (wb_data)
    );

    // A wrong-path instruction is discarded anyway, so it must not stall.
    always_comb begin
        stall_s = 1'b0;
        if (ctrl_q.mem_read && (rd_q != XZR) && !PCSrc && !squash_q) begin
            stall_s = (use_rn_s && (rd_q == rn_s)) || (use_rm_s && (rd_q == rm_s));
        end else begin
            stall_s = 1'b0;
        end
    end

    assign PCWrite     = !stall_s;
    assign IF_ID_Write = !stall_s;
    assign squash_d    = PCSrc;
    assign ctrl_d      = (PCSrc || squash_q || stall_s) ? ctrl_t'(11'b0) : dec_ctrl_s;

    // ID/EX register; bubbles clear controls only, datapath fields always load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= ctrl_t'(11'b0);
            squash_q <= 1'b0;
            rdata1_q <= {DATA_BITS{1'b0}};
            rdata2_q <= {DATA_BITS{1'b0}};
            imm_q    <= {DATA_BITS{1'b0}};
            rn_q     <= {REG_ADDR_BITS{1'b0}};
            rm_q     <= {REG_ADDR_BITS{1'b0}};
            rd_q     <= {REG_ADDR_BITS{1'b0}};
            pc_q     <= {PC_BITS{1'b0}};
        end else begin
            ctrl_q   <= ctrl_d;
            squash_q <= squash_d;
            rdata1_q <= rdata1_s;
            rdata2_q <= rdata2_s;
            imm_q    <= imm_s;
            rn_q     <= rn_s;
            rm_q     <= rm_s;
            rd_q     <= instruction_D[4:0];
            pc_q     <= current_pc_D;
        end
    end

    assign reg_write_E  = ctrl_q.reg_write;
    assign mem_read_E   = ctrl_q.mem_read;
    assign mem_write_E  = ctrl_q.mem_write;
    assign mem_to_reg_E = ctrl_q.mem_to_reg;
    assign alu_src_E    = ctrl_q.alu_src;
    assign branch_E     = ctrl_q.branch;
    assign uncond_E     = ctrl_q.uncond;
    assign alu_ctrl_E   = ctrl_q.alu_ctrl;
    assign read_data1_E = rdata1_q;
    assign read_data2_E = rdata2_q;
    assign imm_E        = imm_q;
    assign rn_E         = rn_q;
    assign rm_E         = rm_q;
    assign rd_E         = rd_q;
    assign pc_E         = pc_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register of the 5-stage LEGv8 pipeline, sitting directly downstream of the fetch stage's IF/ID register. It consumes `instruction_D` and `current_pc_D`, decodes the supported LEGv8 subset, reads the register file, and extends immediates. It detects load-use hazards, driving `PCWrite`/`IF_ID_Write` back to fetch, and squashes wrong-path instructions after a taken branch resolved in EX.

## Interface
Parameters:
- `DATA_BITS`, 64, register/datapath width
- `PC_BITS`, 10, PC width (matches fetch stage)
- `REG_ADDR_BITS`, 5, register index width

Ports:
- `clk` in 1: sole clock, all state on rising edge
- `reset` in 1: reset, asynchronous, active-low
- `instruction_D` in 32: instruction from IF/ID
- `current_pc_D` in PC_BITS: PC from IF/ID
- `PCSrc` in 1: taken branch resolved in EX this cycle
- `wb_en` in 1: write-back enable
- `wb_addr` in 5: write-back register
- `wb_data` in DATA_BITS: write-back data
- `PCWrite` out 1: PC update enable to fetch (comb)
- `IF_ID_Write` out 1: IF/ID load enable to fetch (comb)
- `reg_write_E`, `mem_read_E`, `mem_write_E`, `mem_to_reg_E`, `alu_src_E`, `branch_E`, `uncond_E` out 1 each: registered controls
- `alu_ctrl_E` out 4: AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111
- `read_data1_E`, `read_data2_E`, `imm_E` out DATA_BITS: registered operands
- `rn_E`, `rm_E`, `rd_E` out 5: registered source/destination indices
- `pc_E` out PC_BITS: registered PC

## Operation
- Decode, by opcode:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (R-type): sources Rn[9:5], Rm[20:16]; reg_write=1.
  - LDUR 11111000010: source Rn; alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, ADD.
  - STUR 11111000000: sources Rn, Rt[4:0] (Rt goes to `rm_E` and read port 2); alu_src=1, mem_write=1, ADD.
  - CBZ [31:24]=10110100: source Rt[4:0] on read port 2; branch=1, PASSB.
  - B [31:26]=000101: uncond=1.
- Anything else, including all-zero, decodes as a bubble: all controls 0, alu_ctrl 0000.
- `rd_E` = instr[4:0] for every decoded instruction.
- Immediates, sign-extended to DATA_BITS:
  - D-type: instr[20:12].
  - CB: instr[23:5]<<2.
  - B: instr[25:0]<<2.
  - R-type: 0.
- Register file, 32×DATA_BITS:
  - X31 reads 0 and writes to it are ignored.
  - Write occurs at the rising edge when `wb_en`.
  - Same-cycle bypass: when `wb_en` and `wb_addr`==read index≠31, the read returns `wb_data`.
- Load-use stall (comb) is asserted when all of the following hold:
  - `mem_read_E`=1.
  - `rd_E`≠31.
  - `rd_E` equals a source index actually used by the ID instruction.
  - `PCSrc`=0 and `squash`=0.
- While stalled: `PCWrite`=`IF_ID_Write`=0, and a bubble (controls 0) loads into ID/EX.
- Not stalled: `PCWrite`=`IF_ID_Write`=1.
- Squash flag `squash` is a 1-bit register:
  - It is set at the edge where `PCSrc`=1 and cleared at the next edge.
  - When `PCSrc`=1 or `squash`=1, the ID instruction is wrong-path and ID/EX loads a bubble.
- Bubble clears only control bits. Datapath fields (data, imm, indices, pc) still load, for visibility.

## Timing
- Reset (async, low): every registered output and `squash` = 0; register file contents = 0. `PCWrite`/`IF_ID_Write` read 1 during reset, since `mem_read_E`=0.
- ID/EX latency is 1 cycle: decode results of cycle t appear on the `_E` outputs after edge t.
- Branch resolved in EX at cycle t (`PCSrc`=1): the ID instructions of cycles t and t+1 both become bubbles. The target instruction enters ID at t+2.
- Load-use stall lasts exactly 1 cycle. The bubble clears `mem_read_E`, so the stall releases at t+1 and the stalled instruction re-decodes.
- Priority: `PCSrc` > `squash` > stall > normal.
- Simultaneous write-back and read of the same register: bypassed data is used.
- Reset deasserted mid-pipeline: the first ID/EX load occurs at the first rising edge after release.

## Structure
- Shared package `legv8_pkg`:
  - opcode constants;
  - alu_ctrl encodings;
  - XZR index 31;
  - a control-bundle typedef (7 control bits plus alu_ctrl).
- Sub-module `register_file`: two combinational read ports with bypass, one write port, X31 hardwired to 0.
- Decoder, immediate generation, hazard logic, `squash` register and the ID/EX register stay in the top module.

## Test plan
- Reset held low, then released:
  - all `_E` outputs are 0;
  - `PCWrite`=`IF_ID_Write`=1;
  - reading X5 returns 0.
- Write-back X2=0x1234 with `wb_en`, same cycle decode ADD X3,X2,X2 (0x8B020043) → next cycle `read_data1_E`=`read_data2_E`=0x1234, `reg_write_E`=1, `alu_ctrl_E`=0010, `rd_E`=3.
- LDUR X1,[X0,#8] (0xF84080 01) followed by ADD X4,X1,X2:
  - one cycle `PCWrite`=`IF_ID_Write`=0 and a bubble in ID/EX;
  - ADD then issues normally.
- LDUR X31 followed by ADD X4,X31,X2 → no stall.
- `PCSrc`=1 for one cycle with valid ADDs in ID → the next two ID/EX loads have all controls 0; the third carries the decoded instruction.
- Immediates:
  - CBZ X9 with instr[23:5]=0x7FFFF → `imm_E`=−4 (0xFFFF_FFFF_FFFF_FFFC), `branch_E`=1;
  - B with imm26=1 → `imm_E`=4, `uncond_E`=1.
